// File: rtl/h_xor_unit.sv
// Bitwise XOR with a combinational output and an optional registered copy carrying a valid bit.
// Optional feature macro: HXOR_PARITY_EN adds the parity port (XOR-reduction of out_q).
module h_xor_unit #(
  parameter int WIDTH       = 1,
  parameter int PIPE_STAGES = 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [WIDTH-1:0]             a,
  input  logic [WIDTH-1:0]             b,
  input  logic                         in_valid,
  output logic [WIDTH-1:0]             out,
  output logic [WIDTH-1:0]             out_q,
  output logic                         out_valid,
  output logic [$clog2(WIDTH+1)-1:0]   ones
`ifdef HXOR_PARITY_EN
  ,
  output logic                         parity
`endif
);

  localparam int CW = $clog2(WIDTH+1);

  if (WIDTH < 1 || WIDTH > 64) begin : g_bad_width
    $error("h_xor_unit: WIDTH must be in 1..64");
  end
  if (PIPE_STAGES < 0 || PIPE_STAGES > 4) begin : g_bad_stages
    $error("h_xor_unit: PIPE_STAGES must be in 0..4");
  end

  assign out = a ^ b;

  if (PIPE_STAGES == 0) begin : g_comb
    // No registers exist here, so clk and reset are intentionally left idle.
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ reset;
    assign out_q          = out;
    assign out_valid      = in_valid;
  end else begin : g_pipe
    logic [WIDTH-1:0]       data_r [PIPE_STAGES];
    logic [PIPE_STAGES-1:0] vld_r;

    // Data is shifted every cycle; only the valid bit qualifies it.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        for (int i = 0; i < PIPE_STAGES; i++) begin
          data_r[i] <= '0;
        end
        vld_r <= '0;
      end else begin
        data_r[0] <= out;
        vld_r[0]  <= in_valid;
        for (int i = 1; i < PIPE_STAGES; i++) begin
          data_r[i] <= data_r[i-1];
          vld_r[i]  <= vld_r[i-1];
        end
      end
    end

    assign out_q     = data_r[PIPE_STAGES-1];
    assign out_valid = vld_r[PIPE_STAGES-1];
  end

  always_comb begin
    ones = '0;
    for (int i = 0; i < WIDTH; i++) begin
      ones = ones + CW'(out_q[i]);
    end
  end

`ifdef HXOR_PARITY_EN
  assign parity = ^out_q;
`endif

endmodule

// File: tb/tb_h_xor_unit.sv
// Bench for h_xor_unit: four instances (1-bit/1 stage, 8-bit/2, 8-bit/3, 8-bit/0) share stimulus.
module tb_h_xor_unit;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic       in_valid = 1'b0;

  logic       out1, oq1, ov1;
  logic [0:0] ones1;
  logic [7:0] out2, oq2, out3, oq3, out0, oq0;
  logic       ov2, ov3, ov0;
  logic [3:0] ones2, ones3, ones0;
`ifdef HXOR_PARITY_EN
  logic par1, par2, par3, par0;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  h_xor_unit #(.WIDTH(1), .PIPE_STAGES(1)) u_w1 (
    .clk(clk), .reset(reset), .a(a[0]), .b(b[0]), .in_valid(in_valid),
    .out(out1), .out_q(oq1), .out_valid(ov1), .ones(ones1)
`ifdef HXOR_PARITY_EN
    , .parity(par1)
`endif
  );
  h_xor_unit #(.WIDTH(8), .PIPE_STAGES(2)) u_p2 (
    .clk(clk), .reset(reset), .a(a), .b(b), .in_valid(in_valid),
    .out(out2), .out_q(oq2), .out_valid(ov2), .ones(ones2)
`ifdef HXOR_PARITY_EN
    , .parity(par2)
`endif
  );
  h_xor_unit #(.WIDTH(8), .PIPE_STAGES(3)) u_p3 (
    .clk(clk), .reset(reset), .a(a), .b(b), .in_valid(in_valid),
    .out(out3), .out_q(oq3), .out_valid(ov3), .ones(ones3)
`ifdef HXOR_PARITY_EN
    , .parity(par3)
`endif
  );
  h_xor_unit #(.WIDTH(8), .PIPE_STAGES(0)) u_p0 (
    .clk(clk), .reset(reset), .a(a), .b(b), .in_valid(in_valid),
    .out(out0), .out_q(oq0), .out_valid(ov0), .ones(ones0)
`ifdef HXOR_PARITY_EN
    , .parity(par0)
`endif
  );

  // Reference history: one {valid, a^b} entry per clock edge out of reset.
  // The value seen D edges after capture is the entry D from the back.
  logic [8:0] exp_q[$];

  initial begin
    for (int i = 0; i < 4; i++) exp_q.push_back('0);
  end

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      exp_q.delete();
      for (int i = 0; i < 4; i++) exp_q.push_back('0);
    end else begin
      exp_q.push_back({in_valid, a ^ b});
      if (exp_q.size() > 8) void'(exp_q.pop_front());
    end
  end

  function automatic logic [8:0] exp_at(int d);
    return exp_q[exp_q.size() - d];
  endfunction

  task automatic test_reset();
    #1 reset = 1'b1;
    a = 8'h5A; b = 8'h0F;
    #2;
    n_checks++; if (oq1 !== 1'b0)   $display("FAIL reset_oq1: got %h want 0", oq1);   else n_pass++;
    n_checks++; if (ov1 !== 1'b0)   $display("FAIL reset_ov1: got %h want 0", ov1);   else n_pass++;
    n_checks++; if (oq2 !== 8'h00)  $display("FAIL reset_oq2: got %h want 00", oq2);  else n_pass++;
    n_checks++; if (ov2 !== 1'b0)   $display("FAIL reset_ov2: got %h want 0", ov2);   else n_pass++;
    n_checks++; if (ones2 !== 4'd0) $display("FAIL reset_ones2: got %0d want 0", ones2); else n_pass++;
    n_checks++; if (oq3 !== 8'h00)  $display("FAIL reset_oq3: got %h want 00", oq3);  else n_pass++;
    n_checks++; if (ov3 !== 1'b0)   $display("FAIL reset_ov3: got %h want 0", ov3);   else n_pass++;
    n_checks++; if (out2 !== 8'h55) $display("FAIL reset_out2: got %h want 55", out2); else n_pass++;
`ifdef HXOR_PARITY_EN
    n_checks++; if (par3 !== 1'b0)  $display("FAIL reset_par3: got %h want 0", par3); else n_pass++;
`endif
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_truth_table();
    logic [3:0] tt;
    tt = 4'b0110;  // index {a,b}: 00->0, 01->1, 10->1, 11->0
    for (int i = 0; i < 4; i++) begin
      a[0] = i[1]; b[0] = i[0];
      #1;
      n_checks++; if (out1 !== tt[i]) $display("FAIL truth_%0d_early: got %h want %h", i, out1, tt[i]); else n_pass++;
      #13;
      n_checks++; if (out1 !== tt[i]) $display("FAIL truth_%0d_late: got %h want %h", i, out1, tt[i]); else n_pass++;
    end
    @(negedge clk);
  endtask

  task automatic test_single_bit_pipe();
    a = 8'h01; b = 8'h00; in_valid = 1'b1;
    @(negedge clk);
    n_checks++; if (oq1 !== 1'b1) $display("FAIL w1_oq: got %h want 1", oq1); else n_pass++;
    n_checks++; if (ov1 !== 1'b1) $display("FAIL w1_ov: got %h want 1", ov1); else n_pass++;
    in_valid = 1'b0;
    @(negedge clk);
    n_checks++; if (ov1 !== 1'b0) $display("FAIL w1_ov_drop: got %h want 0", ov1); else n_pass++;
  endtask

  task automatic test_xor_hex();
    a = 8'hF0; b = 8'h3C; in_valid = 1'b1;
    #1;
    n_checks++; if (out2 !== 8'hCC) $display("FAIL hex_out: got %h want cc", out2); else n_pass++;
    @(negedge clk);
    in_valid = 1'b0;
    n_checks++; if (ov2 !== 1'b0) $display("FAIL hex_ov_early: got %h want 0", ov2); else n_pass++;
    @(negedge clk);
    n_checks++; if (oq2 !== 8'hCC)  $display("FAIL hex_oq: got %h want cc", oq2); else n_pass++;
    n_checks++; if (ones2 !== 4'd4) $display("FAIL hex_ones: got %0d want 4", ones2); else n_pass++;
    n_checks++; if (ov2 !== 1'b1)   $display("FAIL hex_ov: got %h want 1", ov2); else n_pass++;
  endtask

  task automatic test_random(int n);
    logic [8:0] e1, e2, e3;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      e1 = exp_at(1); e2 = exp_at(2); e3 = exp_at(3);
      n_checks++; if (oq1 !== e1[0]) $display("FAIL rnd_oq1 #%0d: got %h want %h", k, oq1, e1[0]); else n_pass++;
      n_checks++; if (ov1 !== e1[8]) $display("FAIL rnd_ov1 #%0d: got %h want %h", k, ov1, e1[8]); else n_pass++;
      n_checks++; if (ones1 !== 1'(e1[0])) $display("FAIL rnd_ones1 #%0d: got %0d want %0d", k, ones1, e1[0]); else n_pass++;
      n_checks++; if (oq2 !== e2[7:0]) $display("FAIL rnd_oq2 #%0d: got %h want %h", k, oq2, e2[7:0]); else n_pass++;
      n_checks++; if (ov2 !== e2[8])   $display("FAIL rnd_ov2 #%0d: got %h want %h", k, ov2, e2[8]); else n_pass++;
      n_checks++; if (ones2 !== 4'($countones(e2[7:0]))) $display("FAIL rnd_ones2 #%0d: got %0d want %0d", k, ones2, $countones(e2[7:0])); else n_pass++;
      n_checks++; if (oq3 !== e3[7:0]) $display("FAIL rnd_oq3 #%0d: got %h want %h", k, oq3, e3[7:0]); else n_pass++;
      n_checks++; if (ov3 !== e3[8])   $display("FAIL rnd_ov3 #%0d: got %h want %h", k, ov3, e3[8]); else n_pass++;
      n_checks++; if (ones3 !== 4'($countones(e3[7:0]))) $display("FAIL rnd_ones3 #%0d: got %0d want %0d", k, ones3, $countones(e3[7:0])); else n_pass++;
`ifdef HXOR_PARITY_EN
      n_checks++; if (par2 !== ^e2[7:0]) $display("FAIL rnd_par2 #%0d: got %h want %h", k, par2, ^e2[7:0]); else n_pass++;
      n_checks++; if (par3 !== ^e3[7:0]) $display("FAIL rnd_par3 #%0d: got %h want %h", k, par3, ^e3[7:0]); else n_pass++;
`endif
      a = 8'($urandom); b = 8'($urandom);
      in_valid = ($urandom_range(0, 3) != 0);
      #1;
      n_checks++; if (out3 !== (a ^ b)) $display("FAIL rnd_out3 #%0d: got %h want %h", k, out3, a ^ b); else n_pass++;
      n_checks++; if (oq0 !== (a ^ b))  $display("FAIL rnd_oq0 #%0d: got %h want %h", k, oq0, a ^ b); else n_pass++;
      n_checks++; if (ov0 !== in_valid) $display("FAIL rnd_ov0 #%0d: got %h want %h", k, ov0, in_valid); else n_pass++;
    end
  endtask

  task automatic test_reset_midstream();
    logic [7:0] ed;
    @(negedge clk);
    a = 8'($urandom); b = 8'($urandom); in_valid = 1'b1;
    @(negedge clk);
    a = 8'($urandom); b = 8'($urandom); in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    // Two valid items are now inside the 3-stage pipe, none at its output yet.
    #2 reset = 1'b1;
    #1;
    n_checks++; if (oq3 !== 8'h00)  $display("FAIL mid_oq3: got %h want 00", oq3); else n_pass++;
    n_checks++; if (ov3 !== 1'b0)   $display("FAIL mid_ov3: got %h want 0", ov3); else n_pass++;
    n_checks++; if (ones3 !== 4'd0) $display("FAIL mid_ones3: got %0d want 0", ones3); else n_pass++;
    n_checks++; if (ov2 !== 1'b0)   $display("FAIL mid_ov2: got %h want 0", ov2); else n_pass++;
    n_checks++; if (out3 !== (a ^ b)) $display("FAIL mid_out3: got %h want %h", out3, a ^ b); else n_pass++;
    n_checks++; if (oq0 !== (a ^ b))  $display("FAIL mid_oq0: got %h want %h", oq0, a ^ b); else n_pass++;
    @(negedge clk);
    reset = 1'b0;
    a = 8'($urandom); b = 8'($urandom); in_valid = 1'b1;
    ed = a ^ b;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    n_checks++; if (ov3 !== 1'b0) $display("FAIL mid_lat_early: got %h want 0", ov3); else n_pass++;
    @(negedge clk);
    n_checks++; if (ov3 !== 1'b1) $display("FAIL mid_lat_valid: got %h want 1", ov3); else n_pass++;
    n_checks++; if (oq3 !== ed)   $display("FAIL mid_lat_data: got %h want %h", oq3, ed); else n_pass++;
  endtask

  task automatic test_passthrough();
    for (int k = 0; k < 6; k++) begin
      a = 8'($urandom); b = 8'($urandom); in_valid = 1'($urandom);
      reset = (k == 3);
      #1;
      n_checks++; if (oq0 !== (a ^ b))  $display("FAIL pass_oq0 #%0d: got %h want %h", k, oq0, a ^ b); else n_pass++;
      n_checks++; if (ov0 !== in_valid) $display("FAIL pass_ov0 #%0d: got %h want %h", k, ov0, in_valid); else n_pass++;
      n_checks++; if (ones0 !== 4'($countones(a ^ b))) $display("FAIL pass_ones0 #%0d: got %0d want %0d", k, ones0, $countones(a ^ b)); else n_pass++;
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

`ifdef HXOR_PARITY_EN
  task automatic test_parity();
    a = 8'h01; b = 8'h00;
    #1;
    n_checks++; if (par0 !== 1'b1) $display("FAIL parity_01: got %h want 1", par0); else n_pass++;
    a = 8'h03;
    #1;
    n_checks++; if (par0 !== 1'b0) $display("FAIL parity_03: got %h want 0", par0); else n_pass++;
    @(negedge clk);
  endtask
`endif

  initial begin
    test_reset();
    test_truth_table();
    test_single_bit_pipe();
    test_xor_hex();
    test_random(60);
    test_reset_midstream();
    test_random(20);
    test_passthrough();
`ifdef HXOR_PARITY_EN
    test_parity();
`endif
    test_random(10);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
